// File: rtl/div_pkg.sv
// Shared helpers and limits for the programmable clock divider.
package div_pkg;

    localparam int MAX_CH = 16;

    // Width of a channel index, never narrower than one bit.
    function automatic int ch_idx_w(input int num_ch);
        int w;
        w = $clog2(num_ch);
        return (w < 1) ? 1 : w;
    endfunction

    // Reset half-period for channel idx: clk_hz / (2 * 10^idx), at least 1.
    function automatic longint unsigned default_half(input longint unsigned clk_hz,
                                                     input int idx);
        longint unsigned div;
        longint unsigned q;
        div = 2;
        for (int k = 0; k < idx; k++) begin
            div = div * 10;
        end
        q = clk_hz / div;
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: half-period counter, square wave, toggle tick, and a
// pending half-period that is only taken over at a phase boundary.
// Optional DIV_PENDING_STATUS_EN exposes the pending flag as pend_o.
module div_channel
    import div_pkg::*;
#(
    parameter int                CNT_W    = 30,
    parameter logic [CNT_W-1:0]  DEF_HALF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdata,
`ifdef DIV_PENDING_STATUS_EN
    output logic             pend_o,
`endif
    output logic             tick_o,
    output logic             sq_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             flag_q, flag_d;
    logic             sq_q, sq_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] eff_half;
    logic             tc;

    // Next-state: counting/toggling, then hand-over of a pending half-period.
    always_comb begin
        eff_half  = (active_q == '0) ? CNT_W'(1) : active_q;
        tc        = en && (cnt_q == eff_half - CNT_W'(1));
        cnt_d     = '0;
        sq_d      = 1'b0;
        tick_d    = 1'b0;
        active_d  = active_q;
        pending_d = pending_q;
        flag_d    = flag_q;

        if (!sync_clr && en) begin
            sq_d = sq_q;
            if (tc) begin
                sq_d   = ~sq_q;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Only a value that was already pending may apply; a write landing on
        // the boundary cycle waits for the following boundary.
        if (flag_q && (sync_clr || !en || tc)) begin
            active_d = pending_q;
            flag_d   = 1'b0;
        end

        if (wr) begin
            pending_d = wdata;
            flag_d    = 1'b1;
        end
    end

    // State registers; reset also discards any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            active_q  <= DEF_HALF;
            pending_q <= DEF_HALF;
            flag_q    <= 1'b0;
            sq_q      <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            flag_q    <= flag_d;
            sq_q      <= sq_d;
            tick_q    <= tick_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
`ifdef DIV_PENDING_STATUS_EN
    assign pend_o = flag_q;
`endif

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable square-wave / tick generator.
// Optional DIV_PENDING_STATUS_EN adds pend_o, the per-channel pending flag.
module prog_clk_divider
    import div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 30,
    parameter int CLK_HZ = 50000000,
    localparam int CH_W  = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
`ifdef DIV_PENDING_STATUS_EN
    output logic [NUM_CH-1:0] pend_o,
`endif
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] sq_o
);

    logic [NUM_CH-1:0] wr_vec;

    // Decode the config write into per-channel strobes; out-of-range indices hit nothing.
    always_comb begin
        wr_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_vec[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        div_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (CNT_W'(default_half(CLK_HZ, g)))
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[g]),
            .sync_clr (sync_clr),
            .wr       (wr_vec[g]),
            .wdata    (cfg_half),
`ifdef DIV_PENDING_STATUS_EN
            .pend_o   (pend_o[g]),
`endif
            .tick_o   (tick_o[g]),
            .sq_o     (sq_o[g])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider with CLK_HZ=2000 (halves 1000/100/10/1).
module tb_prog_clk_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        sync_clr;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [29:0] cfg_half;
    logic [3:0]  tick_o;
    logic [3:0]  sq_o;
`ifdef DIV_PENDING_STATUS_EN
    logic [3:0]  pend_o;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;

    prog_clk_divider #(.NUM_CH(4), .CNT_W(30), .CLK_HZ(2000)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (sync_clr),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
`ifdef DIV_PENDING_STATUS_EN
        .pend_o   (pend_o),
`endif
        .tick_o   (tick_o),
        .sq_o     (sq_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [29:0] half);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_half = half;
    endtask

    initial begin
        int halves[4];
        halves = '{1000, 100, 10, 1};
        rst = 1'b0; en = 4'hF; sync_clr = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;

        step(); step();
        check_eq("rst_sq", {28'd0, sq_o}, 32'd0);
        check_eq("rst_tick", {28'd0, tick_o}, 32'd0);
`ifdef DIV_PENDING_STATUS_EN
        check_eq("rst_pend", {28'd0, pend_o}, 32'd0);
`endif
        rst = 1'b1;

        // Defaults: channel i toggles every halves[i] cycles from release.
        for (int n = 1; n <= 1000; n++) begin
            step();
            for (int c = 0; c < 4; c++) begin
                check_eq($sformatf("def_sq%0d_n%0d", c, n), {31'd0, sq_o[c]}, (n / halves[c]) % 2);
                check_eq($sformatf("def_tk%0d_n%0d", c, n), {31'd0, tick_o[c]},
                         {31'd0, (n % halves[c]) == 0});
            end
        end

        // sync_clr at an arbitrary phase.
        for (int n = 0; n < 37; n++) step();
        check_eq("pre_clr_sq0", {31'd0, sq_o[0]}, 32'd1);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check_eq("clr_sq", {28'd0, sq_o}, 32'd0);
        check_eq("clr_tick", {28'd0, tick_o}, 32'd0);

        // Reprogram ch2 to 4 while its counter sits at 3.
        for (int k = 1; k <= 26; k++) begin
            if (k == 4) cfg_write(2'd2, 30'd4);
            step();
            cfg_we = 1'b0;
            check_eq($sformatf("rp_tick_k%0d", k), {28'd0, tick_o},
                     {28'd0, 1'b1, (k == 10) || (k > 10 && (k - 10) % 4 == 0), 2'b00});
            check_eq($sformatf("rp_sq2_k%0d", k), {31'd0, sq_o[2]},
                     (k < 10) ? 32'd0 : ((((k - 10) / 4) % 2 == 0) ? 32'd1 : 32'd0));
`ifdef DIV_PENDING_STATUS_EN
            if (k >= 4) check_eq($sformatf("rp_pend2_k%0d", k), {31'd0, pend_o[2]},
                                 (k < 10) ? 32'd1 : 32'd0);
`endif
        end

        // Clamp on ch1 (write 0) and a write on ch2's exact boundary cycle.
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            int t2;
            if (k == 1) cfg_write(2'd1, 30'd0);
            if (k == 8) cfg_write(2'd2, 30'd6);
            step();
            cfg_we = 1'b0;
            t2 = (k <= 12) ? (k / 4) : (3 + (k - 12) / 6);
            check_eq($sformatf("cl_tk1_k%0d", k), {31'd0, tick_o[1]}, {31'd0, k >= 100});
            check_eq($sformatf("cl_sq1_k%0d", k), {31'd0, sq_o[1]},
                     {31'd0, (k >= 100) && ((k - 100) % 2 == 0)});
            check_eq($sformatf("cl_tk2_k%0d", k), {31'd0, tick_o[2]},
                     {31'd0, (k <= 12) ? (k % 4 == 0) : ((k - 12) % 6 == 0)});
            check_eq($sformatf("cl_sq2_k%0d", k), {31'd0, sq_o[2]}, t2 % 2);
        end

        // Disable ch2 while high, then re-enable.
        en = 4'b1011;
        step();
        check_eq("dis_sq2", {31'd0, sq_o[2]}, 32'd0);
        check_eq("dis_tk2", {31'd0, tick_o[2]}, 32'd0);
        step(); step(); step();
        check_eq("dis_hold_sq2", {31'd0, sq_o[2]}, 32'd0);
        en = 4'hF;
        for (int m = 1; m <= 12; m++) begin
            step();
            check_eq($sformatf("ren_tk2_m%0d", m), {31'd0, tick_o[2]}, {31'd0, m % 6 == 0});
            check_eq($sformatf("ren_sq2_m%0d", m), {31'd0, sq_o[2]}, {31'd0, m >= 6 && m < 12});
        end

        // Async reset with a write pending on ch2.
        cfg_write(2'd2, 30'd50);
        step();
        cfg_we = 1'b0;
`ifdef DIV_PENDING_STATUS_EN
        check_eq("ar_pend_before", {31'd0, pend_o[2]}, 32'd1);
`endif
        check_eq("ar_tk3_before", {31'd0, tick_o[3]}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("ar_sq", {28'd0, sq_o}, 32'd0);
        check_eq("ar_tick", {28'd0, tick_o}, 32'd0);
`ifdef DIV_PENDING_STATUS_EN
        check_eq("ar_pend", {28'd0, pend_o}, 32'd0);
`endif
        step(); step();
        rst = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            check_eq($sformatf("post_tk_k%0d", k), {28'd0, tick_o},
                     {28'd0, 1'b1, k % 10 == 0, 2'b00});
            check_eq($sformatf("post_sq_k%0d", k), {28'd0, sq_o},
                     {28'd0, k % 2 == 1, (k / 10) % 2 == 1, 2'b00});
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
